// File: rtl/datapath_sequencer.sv
// Sequences one instruction through READ/EXEC/WRITE (repeated rep+1 times) and reports it in DONE; res_valid 3*(rep+1)+1 cycles after accept.
// Backpressure: instr_ready only in IDLE, so instr_valid in any other state is ignored.
module datapath_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [ADDR_W-1:0] ra1,
    output logic [ADDR_W-1:0] ra2,
    output logic [ADDR_W-1:0] wa3,
    output logic              we3,
    output logic [DATA_W-1:0] wd3,
    output logic              src_sel,
    output logic [2:0]        ula_ctrl,
    input  logic [DATA_W-1:0] ula_result,
    input  logic              ula_zero,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [15:2]       instr_q, instr_d;
    logic [1:0]        rep_q, rep_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              z_q, z_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_zero_q, out_zero_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            rep_q      <= '0;
            res_q      <= '0;
            z_q        <= 1'b0;
            out_data_q <= '0;
            out_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            rep_q      <= rep_d;
            res_q      <= res_d;
            z_q        <= z_d;
            out_data_q <= out_data_d;
            out_zero_q <= out_zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        rep_d      = rep_q;
        res_d      = res_q;
        z_d        = z_q;
        out_data_d = out_data_q;
        out_zero_d = out_zero_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    instr_d = instr[15:2];
                    rep_d   = instr[1:0];
                    state_d = READ;
                end
            end
            READ: state_d = EXEC;
            EXEC: begin
                res_d   = ula_result;
                z_d     = ula_zero;
                state_d = WRITE;
            end
            WRITE: begin
                if (rep_q != 2'd0) begin
                    rep_d   = rep_q - 2'd1;
                    state_d = READ;
                end else begin
                    // Result outputs only move on entry to DONE so they hold between instructions.
                    out_data_d = res_q;
                    out_zero_d = z_q;
                    state_d    = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ra1         = ADDR_W'(instr_q[9:7]);
        ra2         = ADDR_W'(instr_q[6:4]);
        wa3         = ADDR_W'(instr_q[12:10]);
        ula_ctrl    = instr_q[15:13];
        src_sel     = instr_q[3];
        we3         = (state_q == WRITE) && instr_q[2];
        wd3         = (state_q == WRITE) ? res_q : '0;
        res_valid   = (state_q == DONE);
        res_data    = out_data_q;
        res_zero    = out_zero_q;
        busy        = (state_q != IDLE);
        instr_ready = (state_q == IDLE) && !rst;
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: behavioural register file + ULA environment and an instruction-level reference model.
module tb_datapath_sequencer;

    localparam logic [7:0] IMM = 8'h07;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [15:0] instr;
    logic [2:0] ra1, ra2, wa3;
    logic       we3;
    logic [7:0] wd3;
    logic       src_sel;
    logic [2:0] ula_ctrl;
    logic [7:0] ula_result;
    logic       ula_zero;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_zero;
    logic       busy;

    int vec = 0;
    int err = 0;

    datapath_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .ra1(ra1), .ra2(ra2), .wa3(wa3), .we3(we3), .wd3(wd3),
        .src_sel(src_sel), .ula_ctrl(ula_ctrl), .ula_result(ula_result),
        .ula_zero(ula_zero), .res_valid(res_valid), .res_data(res_data),
        .res_zero(res_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    // Environment: register file written by the DUT, ULA fed from it.
    logic [7:0] rf_hw [8];
    logic [7:0] rf_init [8];
    logic       rf_load = 1'b0;

    always @(posedge clk) begin
        if (rf_load) rf_hw <= rf_init;
        else if (we3) rf_hw[wa3] <= wd3;
    end

    always_comb begin
        ula_result = alu(ula_ctrl, rf_hw[ra1], src_sel ? IMM : rf_hw[ra2]);
        ula_zero   = (ula_result == 8'h00);
    end

    // Reference model state.
    logic [7:0] rf_m [8];
    logic [2:0] exp_wa [$];
    logic [7:0] exp_wd [$];
    logic [7:0] exp_res;
    logic       exp_z;
    int         exp_lat;

    logic [2:0] obs_wa [$];
    logic [7:0] obs_wd [$];

    task automatic model_run(input logic [15:0] ins);
        logic [7:0] r;
        int rep;
        rep = int'(ins[1:0]);
        r = 8'h00;
        exp_wa.delete();
        exp_wd.delete();
        for (int i = 0; i <= rep; i++) begin
            r = alu(ins[15:13], rf_m[ins[9:7]], ins[3] ? IMM : rf_m[ins[6:4]]);
            if (ins[2]) begin
                rf_m[ins[12:10]] = r;
                exp_wa.push_back(ins[12:10]);
                exp_wd.push_back(r);
            end
        end
        exp_res = r;
        exp_z   = (r == 8'h00);
        exp_lat = 3 * (rep + 1) + 1;
    endtask

    task automatic init_rf();
        for (int i = 0; i < 8; i++) begin
            rf_init[i] = 8'($urandom);
            rf_m[i]    = rf_init[i];
        end
    endtask

    task automatic set_reg(input int idx, input logic [7:0] v);
        rf_init[idx] = v;
        rf_m[idx]    = v;
    endtask

    task automatic commit_rf();
        @(negedge clk);
        rf_load = 1'b1;
        @(posedge clk);
        #1 rf_load = 1'b0;
    endtask

    task automatic accept(input logic [15:0] ins, output bit ok);
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        ok          = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (instr_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        instr_valid = 1'b0;
    endtask

    task automatic collect(input logic [15:0] ins, output int lat, output logic [7:0] res,
                           output logic z, output bit ctl_ok);
        obs_wa.delete();
        obs_wd.delete();
        lat = -1; res = 8'hxx; z = 1'bx; ctl_ok = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (we3) begin
                obs_wa.push_back(wa3);
                obs_wd.push_back(wd3);
            end
            if (busy && !res_valid &&
                (ra1 !== ins[9:7] || ra2 !== ins[6:4] || wa3 !== ins[12:10] ||
                 ula_ctrl !== ins[15:13] || src_sel !== ins[3] || instr_ready !== 1'b0))
                ctl_ok = 1'b0;
            if (res_valid) begin
                lat = c; res = res_data; z = res_zero;
                break;
            end
        end
    endtask

    task automatic check_writes(input string name);
        vec++;
        if (obs_wa.size() != exp_wa.size()) begin
            err++;
            $display("FAIL %s write count: got %0d expected %0d", name, obs_wa.size(), exp_wa.size());
        end else begin
            for (int i = 0; i < exp_wa.size(); i++) begin
                vec++;
                if (obs_wa[i] !== exp_wa[i] || obs_wd[i] !== exp_wd[i]) begin
                    err++;
                    $display("FAIL %s write %0d: got r%0d<=%h expected r%0d<=%h",
                             name, i, obs_wa[i], obs_wd[i], exp_wa[i], exp_wd[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b0; instr = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec++;
        if ({ra1, ra2, wa3, we3, wd3, src_sel, ula_ctrl, res_valid, res_data, res_zero, busy, instr_ready} !== 36'd0) begin
            err++;
            $display("FAIL reset outputs: got we3=%b wd3=%h busy=%b ready=%b res=%h valid=%b expected all 0",
                     we3, wd3, busy, instr_ready, res_data, res_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            err++;
            $display("FAIL reset release: got ready=%b busy=%b expected 1 0", instr_ready, busy);
        end
    endtask

    task automatic test_single();
        logic [15:0] ins;
        int lat; logic [7:0] res; logic z; bit ctl_ok, ok;
        ins = {3'b010, 3'b011, 3'b001, 3'b010, 1'b0, 1'b1, 2'b00};
        init_rf();
        set_reg(1, 8'h2A);
        set_reg(2, 8'hFF);
        commit_rf();
        model_run(ins);
        accept(ins, ok);
        vec++;
        if (!ok) begin err++; $display("FAIL single accept: got no ready expected ready"); end
        collect(ins, lat, res, z, ctl_ok);
        vec++;
        if (lat !== 4) begin err++; $display("FAIL single latency: got %0d expected 4", lat); end
        vec++;
        if (res !== 8'h2A || res !== exp_res) begin err++; $display("FAIL single result: got %h expected 2a", res); end
        vec++;
        if (!ctl_ok) begin err++; $display("FAIL single controls: got mismatching ra/ula_ctrl/src_sel expected instr fields"); end
        check_writes("single");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec++;
            if (res_data !== 8'h2A || res_valid !== 1'b0 || we3 !== 1'b0) begin
                err++;
                $display("FAIL single hold: got data=%h valid=%b we3=%b expected 2a 0 0", res_data, res_valid, we3);
            end
        end
    endtask

    task automatic test_repeat();
        logic [15:0] ins;
        int lat; logic [7:0] res; logic z; bit ctl_ok, ok;
        ins = {3'b000, 3'd5, 3'd5, 3'd0, 1'b1, 1'b1, 2'b11};
        init_rf();
        set_reg(5, 8'h00);
        commit_rf();
        model_run(ins);
        accept(ins, ok);
        collect(ins, lat, res, z, ctl_ok);
        vec++;
        if (lat !== 13) begin err++; $display("FAIL repeat latency: got %0d expected 13", lat); end
        vec++;
        if (res !== 8'h1C) begin err++; $display("FAIL repeat result: got %h expected 1c", res); end
        vec++;
        if (!ok || !ctl_ok) begin err++; $display("FAIL repeat controls: got ok=%b ctl=%b expected 1 1", ok, ctl_ok); end
        vec++;
        if (obs_wd.size() != 4 || obs_wd[0] !== 8'h07 || obs_wd[3] !== 8'h1C) begin
            err++;
            $display("FAIL repeat writes: got %0d writes expected 07 0e 15 1c", obs_wd.size());
        end
        check_writes("repeat");
    endtask

    task automatic test_zero_nowrite();
        logic [15:0] ins;
        int lat; logic [7:0] res; logic z; bit ctl_ok, ok;
        ins = {3'b001, 3'd4, 3'd6, 3'd6, 1'b0, 1'b0, 2'b01};
        init_rf();
        commit_rf();
        model_run(ins);
        accept(ins, ok);
        collect(ins, lat, res, z, ctl_ok);
        vec++;
        if (obs_wa.size() != 0) begin err++; $display("FAIL zero we3: got %0d writes expected 0", obs_wa.size()); end
        vec++;
        if (res !== 8'h00 || z !== 1'b1) begin err++; $display("FAIL zero result: got %h z=%b expected 00 z=1", res, z); end
        vec++;
        if (lat !== exp_lat || !ok) begin err++; $display("FAIL zero latency: got %0d expected %0d", lat, exp_lat); end
    endtask

    task automatic test_backpressure();
        logic [15:0] ins;
        int lat, nres; logic [7:0] res; bit ok, ready_bad, extra;
        ins = {3'($urandom_range(0, 4)), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'b1, 2'b01};
        init_rf();
        commit_rf();
        model_run(ins);
        accept(ins, ok);
        obs_wa.delete(); obs_wd.delete();
        lat = -1; nres = 0; ready_bad = 1'b0; res = 8'hxx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 2) begin instr = ~ins; instr_valid = 1'b1; end
            else instr_valid = 1'b0;
            if (lat < 0 && instr_ready) ready_bad = 1'b1;
            if (we3) begin obs_wa.push_back(wa3); obs_wd.push_back(wd3); end
            if (res_valid) begin
                nres++;
                if (lat < 0) begin lat = c; res = res_data; end
            end
        end
        extra = (nres != 1) || busy;
        vec++;
        if (ready_bad) begin err++; $display("FAIL backpressure ready: got ready=1 while busy expected 0"); end
        vec++;
        if (extra) begin err++; $display("FAIL backpressure execs: got %0d results busy=%b expected 1 0", nres, busy); end
        vec++;
        if (lat !== exp_lat || res !== exp_res) begin
            err++;
            $display("FAIL backpressure result: got lat=%0d res=%h expected %0d %h", lat, res, exp_lat, exp_res);
        end
        check_writes("backpressure");
    endtask

    task automatic test_reset_mid();
        logic [15:0] ins;
        bit ok, seen;
        ins = {3'b011, 3'd2, 3'd1, 3'd3, 1'b0, 1'b1, 2'b00};
        init_rf();
        commit_rf();
        accept(ins, ok);
        repeat (3) @(negedge clk);
        vec++;
        if (we3 !== 1'b1) begin err++; $display("FAIL midreset write state: got we3=%b expected 1", we3); end
        rst = 1'b1;
        @(negedge clk);
        vec++;
        if ({ra1, ra2, wa3, we3, wd3, src_sel, ula_ctrl, res_valid, res_data, res_zero, busy, instr_ready} !== 36'd0) begin
            err++;
            $display("FAIL midreset outputs: got we3=%b busy=%b valid=%b ra1=%0d wd3=%h expected all 0",
                     we3, busy, res_valid, ra1, wd3);
        end
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if (instr_ready !== 1'b1) begin err++; $display("FAIL midreset release: got ready=%b expected 1", instr_ready); end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (res_valid || busy) seen = 1'b1;
        end
        vec++;
        if (seen) begin err++; $display("FAIL midreset abort: got activity after reset expected none"); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b;
        logic [7:0] ea, eb;
        int t [2]; logic [7:0] r [2];
        int n; bit ok, rdy5;
        a = {3'($urandom_range(0, 4)), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'b1, 2'b00};
        b = {3'($urandom_range(0, 4)), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'b1, 2'b00};
        init_rf();
        commit_rf();
        model_run(a); ea = exp_res;
        model_run(b); eb = exp_res;
        @(negedge clk);
        instr = a; instr_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (instr_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        #1 instr = b;
        n = 0; rdy5 = 1'b0; t[0] = -1; t[1] = -1; r[0] = 8'hxx; r[1] = 8'hxx;
        for (int c = 1; c <= 40 && n < 2; c++) begin
            @(negedge clk);
            if (c == 5) rdy5 = instr_ready;
            if (res_valid) begin t[n] = c; r[n] = res_data; n++; end
        end
        instr_valid = 1'b0;
        vec++;
        if (!ok || t[0] !== 4 || t[1] !== 9) begin
            err++;
            $display("FAIL b2b timing: got pulses at %0d and %0d expected 4 and 9", t[0], t[1]);
        end
        vec++;
        if (!rdy5) begin err++; $display("FAIL b2b ready: got 0 in cycle after DONE expected 1"); end
        vec++;
        if (r[0] !== ea || r[1] !== eb) begin
            err++;
            $display("FAIL b2b results: got %h %h expected %h %h", r[0], r[1], ea, eb);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] ins;
        int lat; logic [7:0] res; logic z; bit ctl_ok, ok;
        init_rf();
        commit_rf();
        for (int n = 0; n < 30; n++) begin
            ins = {3'($urandom_range(0, 4)), 13'($urandom)};
            model_run(ins);
            accept(ins, ok);
            collect(ins, lat, res, z, ctl_ok);
            vec++;
            if (!ok || lat !== exp_lat || res !== exp_res || z !== exp_z || !ctl_ok) begin
                err++;
                $display("FAIL random %0d instr=%h: got lat=%0d res=%h z=%b ctl=%b expected %0d %h %b 1",
                         n, ins, lat, res, z, ctl_ok, exp_lat, exp_res, exp_z);
            end
            check_writes("random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_zero_nowrite();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of register-file data, ULA result and result outputs.
REQ-002 Parameter ADDR_W, default 3, SHALL set the width of register addresses (8 registers).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 instr_valid  input  1  SHALL indicate instr carries a valid instruction.
REQ-006 instr_ready  output  1  SHALL indicate the block accepts an instruction this cycle.
REQ-007 instr  input  16  SHALL use these fields: [15:13] ula_op, [12:10] wa, [9:7] ra1, [6:4] ra2, [3] src_imm, [2] wr_en, [1:0] rep.
REQ-008 ra1, ra2, wa3  output  ADDR_W each  SHALL drive the register-file read and write addresses.
REQ-009 we3  output  1  SHALL drive the register-file write enable.
REQ-010 wd3  output  DATA_W  SHALL drive the register-file write data.
REQ-011 src_sel  output  1  SHALL drive the ULA src_B mux select (0 = rd2, 1 = immediate).
REQ-012 ula_ctrl  output  3  SHALL drive the ULA control input.
REQ-013 ula_result  input  DATA_W  and  ula_zero  input  1  SHALL carry the ULA result and Z flag.
REQ-014 res_valid  output  1, res_data  output  DATA_W, res_zero  output  1  SHALL report the final result of each instruction.
REQ-015 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly five states: IDLE, READ, EXEC, WRITE, DONE.
REQ-017 IDLE: instr_ready = 1; a handshake occurs on instr_valid && instr_ready at a rising edge.
REQ-018 On handshake the block SHALL latch instr, load rep_cnt = instr[1:0], and enter READ.
REQ-019 instr_ready SHALL be 0 in every state except IDLE; instr_valid outside IDLE SHALL be ignored.
REQ-020 From the latched instruction, ra1, ra2, wa3, ula_ctrl and src_sel SHALL be driven constant from READ through WRITE.
REQ-021 READ SHALL last one cycle (settling of combinational read and ULA) and then enter EXEC.
REQ-022 EXEC SHALL capture ula_result into res_reg and ula_zero into z_reg, then enter WRITE.
REQ-023 WRITE: wd3 = res_reg; we3 = wr_en for exactly this one cycle; we3 SHALL be 0 in all other states.
REQ-024 From WRITE: if rep_cnt != 0, decrement rep_cnt and return to READ; otherwise enter DONE.
REQ-025 Repeats SHALL re-read the register file, so a write to ra1 or ra2 by one iteration is visible to the next.
REQ-026 DONE SHALL assert res_valid for exactly one cycle with res_data = res_reg and res_zero = z_reg, then enter IDLE.
REQ-027 res_data and res_zero SHALL hold their last values until the next DONE.
REQ-028 Latency: res_valid SHALL be high in cycle 3*(rep+1)+1 after the accepting edge (rep = 0 gives 4 cycles; rep = 3 gives 13 cycles).
REQ-029 wr_en = 0 SHALL perform all iterations with no register-file write.
REQ-030 When instr_valid is held high, back-to-back instructions SHALL be accepted in the IDLE cycle that follows DONE.

Reset
REQ-031 While rst = 1 at an edge, the state SHALL become IDLE and the following SHALL be 0: ra1, ra2, wa3, we3, wd3, src_sel, ula_ctrl, res_valid, res_data, res_zero, busy, rep_cnt and the latched instruction.
REQ-032 instr_ready SHALL be 0 while rst is high and SHALL be 1 in the first cycle after rst is released.
REQ-033 rst asserted in any state, including WRITE, SHALL suppress we3 in the following cycle and abort the instruction with no res_valid.

Verification
REQ-034 Single op: instr = {010,011,001,010,0,1,00}, bench ULA returns 8'h2A -> ra1 = 1, ra2 = 2, ula_ctrl = 010, src_sel = 0; we3 high for one cycle with wa3 = 3 and wd3 = 8'h2A; res_valid in cycle 4 with res_data = 8'h2A.
REQ-035 Repeat: rep = 3, src_imm = 1, ra1 = wa = 5, bench ULA model = rd1 + 8'h07, r5 = 0 -> four we3 pulses writing 07, 0E, 15, 1C; res_valid in cycle 13 with res_data = 8'h1C.
REQ-036 Zero flag with no write: wr_en = 0, ula_zero = 1, ula_result = 0 -> we3 never asserts; res_zero = 1; res_data = 0.
REQ-037 Backpressure: instr_valid pulsed during EXEC -> pulse ignored; instr_ready stays 0 until IDLE; no second execution.
REQ-038 Reset mid-op: rst asserted in WRITE -> next cycle state is IDLE, all outputs 0, no res_valid; instr_ready = 1 after release.
REQ-039 Back-to-back: instr_valid held high with two instructions -> second accepted in the cycle after DONE; res_valid pulses 5 cycles apart for rep = 0.
